// File: rtl/cache_mem_arbiter.sv
// Memory-side arbiter for the icache/dcache pair. Accepts icache reads and
// dcache reads/writes, serialises them onto one single-ported RAM and returns
// a one-cycle wait-release pulse to the cache that was served. All outputs
// are registered, so there is no combinational path from request to strobe.
module cache_mem_arbiter #(
  parameter int          TIMEOUT  = 64,
  parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SERVE_I  = 3'd1,
    SERVE_DR = 3'd2,
    SERVE_DW = 3'd3,
    RESP_I   = 3'd4,
    RESP_D   = 3'd5
  } state_t;

  localparam int             CW         = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0]  CNT_ONE    = CW'(1);
  localparam logic [CW-1:0]  CNT_LAST   = CW'(TIMEOUT - 1);
  localparam logic [1:0]     RAM_ACCESS = 2'd2;
  localparam logic [1:0]     RAM_ERROR  = 2'd3;
  localparam logic           GRANT_I    = 1'b0;
  localparam logic           GRANT_D    = 1'b1;

  state_t        state, state_next;
  logic          last_grant, last_grant_next;
  logic [CW-1:0] count, count_next;
  logic          iwait_next, dwait_next;
  logic [31:0]   iload_next, dload_next;
  logic          ramREN_next, ramWEN_next;
  logic [31:0]   ramaddr_next, ramstore_next;
  logic          err_next;
  logic          d_req, grant_d, done;
  logic [31:0]   word;

  // Next-state and next-output computation for the arbitration FSM.
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    count_next      = count;
    iwait_next      = 1'b1;
    dwait_next      = 1'b1;
    iload_next      = iload;
    dload_next      = dload;
    ramREN_next     = ramREN;
    ramWEN_next     = ramWEN;
    ramaddr_next    = ramaddr;
    ramstore_next   = ramstore;
    err_next        = err;
    d_req           = dREN | dWEN;
    grant_d         = 1'b0;
    done            = 1'b0;
    word            = ERR_WORD;

    case (state)
      IDLE: begin
        if (iREN || d_req) begin
          // Alternate only when both sides contend; a lone requester always wins.
          grant_d    = d_req && (!iREN || (last_grant == GRANT_I));
          count_next = CNT_ZERO;
          if (grant_d) begin
            last_grant_next = GRANT_D;
            ramaddr_next    = daddr;
            if (dWEN) begin
              // A simultaneous read+write request is a write.
              state_next    = SERVE_DW;
              ramWEN_next   = 1'b1;
              ramREN_next   = 1'b0;
              ramstore_next = dstore;
            end else begin
              state_next  = SERVE_DR;
              ramREN_next = 1'b1;
              ramWEN_next = 1'b0;
            end
          end else begin
            last_grant_next = GRANT_I;
            ramaddr_next    = iaddr;
            state_next      = SERVE_I;
            ramREN_next     = 1'b1;
            ramWEN_next     = 1'b0;
          end
        end else begin
          state_next = IDLE;
        end
      end

      SERVE_I, SERVE_DR, SERVE_DW: begin
        count_next = count + CNT_ONE;
        if (ramstate == RAM_ACCESS) begin
          done = 1'b1;
          word = ramload;
        end else if ((ramstate == RAM_ERROR) || (count == CNT_LAST)) begin
          // RAM error or a stuck access: abort with the poison word.
          done     = 1'b1;
          word     = ERR_WORD;
          err_next = 1'b1;
        end else begin
          done = 1'b0;
        end

        if (done) begin
          ramREN_next = 1'b0;
          ramWEN_next = 1'b0;
          if (state == SERVE_I) begin
            iload_next = word;
            iwait_next = 1'b0;
            state_next = RESP_I;
          end else begin
            dwait_next = 1'b0;
            state_next = RESP_D;
            if (state == SERVE_DR) begin
              dload_next = word;
            end else begin
              dload_next = dload;
            end
          end
        end else begin
          state_next = state;
        end
      end

      RESP_I, RESP_D: begin
        count_next = CNT_ZERO;
        state_next = IDLE;
      end

      default: begin
        state_next  = IDLE;
        count_next  = CNT_ZERO;
        ramREN_next = 1'b0;
        ramWEN_next = 1'b0;
      end
    endcase
  end

  // State register and registered outputs; reset drops the RAM strobes at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      count      <= CNT_ZERO;
      iwait      <= 1'b1;
      dwait      <= 1'b1;
      iload      <= 32'h0000_0000;
      dload      <= 32'h0000_0000;
      ramREN     <= 1'b0;
      ramWEN     <= 1'b0;
      ramaddr    <= 32'h0000_0000;
      ramstore   <= 32'h0000_0000;
      err        <= 1'b0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      count      <= count_next;
      iwait      <= iwait_next;
      dwait      <= dwait_next;
      iload      <= iload_next;
      dload      <= dload_next;
      ramREN     <= ramREN_next;
      ramWEN     <= ramWEN_next;
      ramaddr    <= ramaddr_next;
      ramstore   <= ramstore_next;
      err        <= err_next;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: cycle-by-cycle vector table for the
// read, arbitration, write and error flows, plus hand sequences for reset
// during an access and the RAM timeout.
module tb_cache_mem_arbiter;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, RERR = 2'd3;
  localparam logic [31:0] BAD = 32'hBAD1BAD1;
  localparam int TMO = 64;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = 32'd0, daddr = 32'd0, dstore = 32'd0, ramload = 32'd0;
  logic [1:0]  ramstate = 2'd0;
  logic        iwait, dwait, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int errors = 0;
  int checks = 0;

  cache_mem_arbiter #(.TIMEOUT(TMO), .ERR_WORD(BAD)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        i_ren;
    logic [31:0] i_addr;
    logic        d_ren;
    logic        d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_store;
    logic [1:0]  rs;
    logic [31:0] rl;
    logic        e_iwait;
    logic        e_dwait;
    logic        e_ren;
    logic        e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_store;
    logic [31:0] e_iload;
    logic [31:0] e_dload;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                     input logic [31:0] da, input logic [31:0] ds, input logic [1:0] rs,
                     input logic [31:0] rl, input logic eiw, input logic edw, input logic eren,
                     input logic ewen, input logic [31:0] ea, input logic [31:0] es,
                     input logic [31:0] eil, input logic [31:0] edl, input logic eerr);
    vec_t v;
    v.i_ren = ir; v.i_addr = ia; v.d_ren = dr; v.d_wen = dw; v.d_addr = da; v.d_store = ds;
    v.rs = rs; v.rl = rl; v.e_iwait = eiw; v.e_dwait = edw; v.e_ren = eren; v.e_wen = ewen;
    v.e_addr = ea; v.e_store = es; v.e_iload = eil; v.e_dload = edl; v.e_err = eerr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic invariants(input int idx);
    chk("waits_both_low", idx, {31'd0, (!iwait && !dwait)}, 32'd0);
    chk("strobes_both_high", idx, {31'd0, (ramREN && ramWEN)}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset values ----------------
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_iwait", 0, {31'd0, iwait}, 32'd1);
    chk("rst_dwait", 0, {31'd0, dwait}, 32'd1);
    chk("rst_ramREN", 0, {31'd0, ramREN}, 32'd0);
    chk("rst_ramWEN", 0, {31'd0, ramWEN}, 32'd0);
    chk("rst_err", 0, {31'd0, err}, 32'd0);
    chk("rst_iload", 0, iload, 32'd0);
    chk("rst_dload", 0, dload, 32'd0);
    chk("rst_ramaddr", 0, ramaddr, 32'd0);
    RST = 1'b0;

    // ---------------- reset in the middle of a write ----------------
    dWEN = 1'b1; daddr = 32'h10; dstore = 32'h55;
    tick();
    chk("mid_wen_on", 1, {31'd0, ramWEN}, 32'd1);
    chk("mid_addr", 1, ramaddr, 32'h10);
    #2;
    RST = 1'b1;
    #1;
    chk("mid_rst_wen", 2, {31'd0, ramWEN}, 32'd0);
    chk("mid_rst_store", 2, ramstore, 32'd0);
    chk("mid_rst_iwait", 2, {31'd0, iwait}, 32'd1);
    chk("mid_rst_dwait", 2, {31'd0, dwait}, 32'd1);
    chk("mid_rst_err", 2, {31'd0, err}, 32'd0);
    dWEN = 1'b0; daddr = 32'd0; dstore = 32'd0;
    tick();
    RST = 1'b0;
    tick();
    chk("post_rst_ren", 3, {31'd0, ramREN}, 32'd0);
    chk("post_rst_wen", 3, {31'd0, ramWEN}, 32'd0);

    // ---------------- vector table ----------------
    // single icache read, ACCESS on second strobe cycle
    add(1, 32'h40, 0, 0, 0, 0, FREE, 0,            1, 1, 1, 0, 32'h40, 0, 0, 0, 0);
    add(1, 32'h40, 0, 0, 0, 0, BUSY, 0,            1, 1, 1, 0, 32'h40, 0, 0, 0, 0);
    add(1, 32'h40, 0, 0, 0, 0, ACC, 32'h8C220004,  0, 1, 0, 0, 32'h40, 0, 32'h8C220004, 0, 0);
    add(1, 32'h40, 0, 0, 0, 0, FREE, 0,            1, 1, 0, 0, 32'h40, 0, 32'h8C220004, 0, 0);
    add(0, 32'h40, 0, 0, 0, 0, FREE, 0,            1, 1, 0, 0, 32'h40, 0, 32'h8C220004, 0, 0);
    // contention with last grant = icache: dcache, icache, dcache
    add(1, 32'h100, 1, 0, 32'h200, 0, FREE, 0,          1, 1, 1, 0, 32'h200, 0, 32'h8C220004, 0, 0);
    add(1, 32'h100, 1, 0, 32'h200, 0, ACC, 32'h11111111, 1, 0, 0, 0, 32'h200, 0, 32'h8C220004, 32'h11111111, 0);
    add(1, 32'h100, 1, 0, 32'h200, 0, FREE, 0,          1, 1, 0, 0, 32'h200, 0, 32'h8C220004, 32'h11111111, 0);
    add(1, 32'h100, 1, 0, 32'h204, 0, FREE, 0,          1, 1, 1, 0, 32'h100, 0, 32'h8C220004, 32'h11111111, 0);
    add(1, 32'h100, 1, 0, 32'h204, 0, ACC, 32'h22222222, 0, 1, 0, 0, 32'h100, 0, 32'h22222222, 32'h11111111, 0);
    add(1, 32'h100, 1, 0, 32'h204, 0, FREE, 0,          1, 1, 0, 0, 32'h100, 0, 32'h22222222, 32'h11111111, 0);
    add(1, 32'h100, 1, 0, 32'h204, 0, FREE, 0,          1, 1, 1, 0, 32'h204, 0, 32'h22222222, 32'h11111111, 0);
    add(0, 32'h100, 1, 0, 32'h204, 0, ACC, 32'h33333333, 1, 0, 0, 0, 32'h204, 0, 32'h22222222, 32'h33333333, 0);
    add(0, 32'h100, 0, 0, 32'h204, 0, FREE, 0,          1, 1, 0, 0, 32'h204, 0, 32'h22222222, 32'h33333333, 0);
    // dcache write (with dREN also high), dload must not change
    add(0, 0, 1, 1, 32'h3FC, 32'hDEADBEEF, FREE, 0,           1, 1, 0, 1, 32'h3FC, 32'hDEADBEEF, 32'h22222222, 32'h33333333, 0);
    add(0, 0, 1, 1, 32'h3FC, 32'hDEADBEEF, BUSY, 32'h99999999, 1, 1, 0, 1, 32'h3FC, 32'hDEADBEEF, 32'h22222222, 32'h33333333, 0);
    add(0, 0, 1, 1, 32'h3FC, 32'hDEADBEEF, ACC, 32'h99999999,  1, 0, 0, 0, 32'h3FC, 32'hDEADBEEF, 32'h22222222, 32'h33333333, 0);
    add(0, 0, 1, 1, 32'h3FC, 32'hDEADBEEF, FREE, 0,           1, 1, 0, 0, 32'h3FC, 32'hDEADBEEF, 32'h22222222, 32'h33333333, 0);
    add(0, 0, 0, 0, 32'h3FC, 32'hDEADBEEF, FREE, 0,           1, 1, 0, 0, 32'h3FC, 32'hDEADBEEF, 32'h22222222, 32'h33333333, 0);
    // RAM error on icache read, queued dcache read served normally
    add(1, 32'h80, 1, 0, 32'h84, 0, FREE, 0,          1, 1, 1, 0, 32'h80, 32'hDEADBEEF, 32'h22222222, 32'h33333333, 0);
    add(1, 32'h80, 1, 0, 32'h84, 0, RERR, 0,          0, 1, 0, 0, 32'h80, 32'hDEADBEEF, BAD, 32'h33333333, 1);
    add(1, 32'h80, 1, 0, 32'h84, 0, FREE, 0,          1, 1, 0, 0, 32'h80, 32'hDEADBEEF, BAD, 32'h33333333, 1);
    add(0, 32'h80, 1, 0, 32'h84, 0, FREE, 0,          1, 1, 1, 0, 32'h84, 32'hDEADBEEF, BAD, 32'h33333333, 1);
    add(0, 32'h80, 1, 0, 32'h84, 0, ACC, 32'h44444444, 1, 0, 0, 0, 32'h84, 32'hDEADBEEF, BAD, 32'h44444444, 1);
    add(0, 32'h80, 0, 0, 32'h84, 0, FREE, 0,          1, 1, 0, 0, 32'h84, 32'hDEADBEEF, BAD, 32'h44444444, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      iREN = vecs[i].i_ren; iaddr = vecs[i].i_addr;
      dREN = vecs[i].d_ren; dWEN = vecs[i].d_wen;
      daddr = vecs[i].d_addr; dstore = vecs[i].d_store;
      ramstate = vecs[i].rs; ramload = vecs[i].rl;
      tick();
      chk("iwait", i, {31'd0, iwait}, {31'd0, vecs[i].e_iwait});
      chk("dwait", i, {31'd0, dwait}, {31'd0, vecs[i].e_dwait});
      chk("ramREN", i, {31'd0, ramREN}, {31'd0, vecs[i].e_ren});
      chk("ramWEN", i, {31'd0, ramWEN}, {31'd0, vecs[i].e_wen});
      chk("ramaddr", i, ramaddr, vecs[i].e_addr);
      chk("ramstore", i, ramstore, vecs[i].e_store);
      chk("iload", i, iload, vecs[i].e_iload);
      chk("dload", i, dload, vecs[i].e_dload);
      chk("err", i, {31'd0, err}, {31'd0, vecs[i].e_err});
      invariants(i);
    end

    // ---------------- reset clears sticky err ----------------
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = FREE; ramload = 32'd0;
    RST = 1'b1;
    tick();
    chk("rst2_err", 100, {31'd0, err}, 32'd0);
    RST = 1'b0;
    tick();

    // ---------------- timeout on a dcache read ----------------
    dREN = 1'b1; daddr = 32'h500; ramstate = BUSY;
    tick();
    chk("tmo_grant_ren", 200, {31'd0, ramREN}, 32'd1);
    chk("tmo_grant_addr", 200, ramaddr, 32'h500);
    for (int j = 1; j < TMO; j++) begin
      tick();
      chk("tmo_hold_dwait", 200 + j, {31'd0, dwait}, 32'd1);
      chk("tmo_hold_ren", 200 + j, {31'd0, ramREN}, 32'd1);
    end
    tick();
    chk("tmo_dwait", 300, {31'd0, dwait}, 32'd0);
    chk("tmo_dload", 300, dload, BAD);
    chk("tmo_err", 300, {31'd0, err}, 32'd1);
    chk("tmo_ren_drop", 300, {31'd0, ramREN}, 32'd0);
    dREN = 1'b0; ramstate = FREE;
    tick();
    chk("tmo_dwait_rel", 301, {31'd0, dwait}, 32'd1);

    // good access afterwards: err stays set
    iREN = 1'b1; iaddr = 32'h600;
    tick();
    chk("sticky_ren", 302, {31'd0, ramREN}, 32'd1);
    ramstate = ACC; ramload = 32'h55AA55AA;
    tick();
    chk("sticky_iwait", 303, {31'd0, iwait}, 32'd0);
    chk("sticky_iload", 303, iload, 32'h55AA55AA);
    chk("sticky_err", 303, {31'd0, err}, 32'd1);
    iREN = 1'b0; ramstate = FREE;
    tick();
    chk("sticky_iwait_rel", 304, {31'd0, iwait}, 32'd1);
    chk("sticky_err2", 304, {31'd0, err}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
